// File: rtl/deserializer_if.sv
// Bus bundle between the serial link receiver and its consumer.
// The slave modport is the deserializer side; the master modport is the peer.
interface deserializer_if #(
  parameter int DATA_W = 16,
  parameter int MOD_W  = $clog2(DATA_W)
);
  logic              ser_data_i;
  logic              ser_data_val_i;
  logic [DATA_W-1:0] deser_data_o;
  logic [MOD_W-1:0]  deser_data_mod_o;
  logic              deser_data_val_o;
  logic              deser_err_o;
  logic              busy_o;

  modport slave (
    input  ser_data_i,
    input  ser_data_val_i,
    output deser_data_o,
    output deser_data_mod_o,
    output deser_data_val_o,
    output deser_err_o,
    output busy_o
  );

  modport master (
    output ser_data_i,
    output ser_data_val_i,
    input  deser_data_o,
    input  deser_data_mod_o,
    input  deser_data_val_o,
    input  deser_err_o,
    input  busy_o
  );
endinterface

// File: rtl/deserializer.sv
// Serial-to-parallel receiver: collects MSB-first frames of 1..DATA_W bits into
// left-aligned words, reports the bit count, and drops frames shorter than MIN_LEN.
module deserializer #(
  parameter int DATA_W  = 16,
  parameter int MOD_W   = $clog2(DATA_W),
  parameter int MIN_LEN = 3
) (
  input  logic           clk_i,
  input  logic           arst_n_i,
  deserializer_if.slave  bus
);

  localparam int                CNT_W    = MOD_W + 1;
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MIN  = CNT_W'(MIN_LEN);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [MOD_W-1:0]  mod_q,   mod_d;
  logic              val_q,   val_d;
  logic              err_q,   err_d;
  logic              busy_q,  busy_d;
  logic [DATA_W-1:0] bit_vec_s;

  // Incoming bit placed at position DATA_W-1-cnt; cnt is zero in IDLE so it lands in the MSB.
  assign bit_vec_s = {bus.ser_data_i, {(DATA_W-1){1'b0}}} >> cnt_q;

  // Next-state, shift/count and output-register logic.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    mod_d   = mod_q;
    val_d   = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.ser_data_val_i) begin
          if (DATA_W == 1) begin
            data_d = bit_vec_s;
            mod_d  = {MOD_W{1'b0}};
            val_d  = 1'b1;
            cnt_d  = CNT_ZERO;
          end else begin
            shift_d = bit_vec_s;
            cnt_d   = CNT_ONE;
            state_d = COLLECT;
          end
        end else begin
          cnt_d   = CNT_ZERO;
          state_d = IDLE;
        end
      end
      COLLECT: begin
        if (bus.ser_data_val_i) begin
          if (cnt_q == CNT_LAST) begin
            // Full frame: emit on this edge so a continuous stream is split without losing bits.
            data_d  = shift_q | bit_vec_s;
            mod_d   = {MOD_W{1'b0}};
            val_d   = 1'b1;
            cnt_d   = CNT_ZERO;
            state_d = IDLE;
          end else begin
            shift_d = shift_q | bit_vec_s;
            cnt_d   = cnt_q + CNT_ONE;
          end
        end else begin
          if (cnt_q >= CNT_MIN) begin
            data_d = shift_q;
            mod_d  = cnt_q[MOD_W-1:0];
            val_d  = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
          cnt_d   = CNT_ZERO;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        shift_d = {DATA_W{1'b0}};
        cnt_d   = CNT_ZERO;
      end
    endcase

    busy_d = (state_d == COLLECT);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= IDLE;
      shift_q <= {DATA_W{1'b0}};
      cnt_q   <= CNT_ZERO;
      data_q  <= {DATA_W{1'b0}};
      mod_q   <= {MOD_W{1'b0}};
      val_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      mod_q   <= mod_d;
      val_q   <= val_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.deser_data_o     = data_q;
  assign bus.deser_data_mod_o = mod_q;
  assign bus.deser_data_val_o = val_q;
  assign bus.deser_err_o      = err_q;
  assign bus.busy_o           = busy_q;

  deserializer_chk #(
    .CNT_W (CNT_W)
  ) u_chk (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .val_i    (val_q),
    .err_i    (err_q),
    .busy_i   (busy_q),
    .cnt_i    (cnt_q)
  );

endmodule

// Output-protocol invariants of the deserializer.
module deserializer_chk #(
  parameter int CNT_W = 5
) (
  input logic             clk_i,
  input logic             arst_n_i,
  input logic             val_i,
  input logic             err_i,
  input logic             busy_i,
  input logic [CNT_W-1:0] cnt_i
);

  a_val_err_excl: assert property (@(posedge clk_i) disable iff (!arst_n_i)
    !(val_i && err_i));

  a_val_one_cycle: assert property (@(posedge clk_i) disable iff (!arst_n_i)
    val_i |=> !val_i);

  a_err_one_cycle: assert property (@(posedge clk_i) disable iff (!arst_n_i)
    err_i |=> !err_i);

  a_busy_cnt: assert property (@(posedge clk_i) disable iff (!arst_n_i)
    busy_i == (cnt_i != {CNT_W{1'b0}}));

endmodule

// File: tb/tb_deserializer.sv
// Scoreboard bench for the deserializer: expected pulses are queued as frames are driven
// and checked (content and arrival cycle) as the DUT reports them.
module tb_deserializer;

  localparam int DATA_W = 16;
  localparam int MOD_W  = 4;

  logic clk    = 1'b0;
  logic arst_n = 1'b0;

  always #5 clk = ~clk;

  deserializer_if #(.DATA_W(DATA_W), .MOD_W(MOD_W)) bus ();

  deserializer #(
    .DATA_W  (DATA_W),
    .MOD_W   (MOD_W),
    .MIN_LEN (3)
  ) dut (
    .clk_i    (clk),
    .arst_n_i (arst_n),
    .bus      (bus)
  );

  typedef struct {
    bit          is_err;
    logic [15:0] data;
    logic [3:0]  mod;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          vectors      = 0;
  int          miscompares  = 0;
  int          cyc          = 0;
  int          last_bit_cyc = 0;
  int          busy_cnt     = 0;
  logic [15:0] last_data    = 16'h0000;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sampled on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    exp_t e;
    if (bus.busy_o) busy_cnt++;
    if (bus.deser_data_val_o && bus.deser_err_o)
      check_val("val_err_overlap", 32'd1, 32'd0);
    if (bus.deser_data_val_o || bus.deser_err_o) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_pulse", {30'd0, bus.deser_data_val_o, bus.deser_err_o}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_val("pulse_kind", {31'd0, bus.deser_err_o}, {31'd0, e.is_err});
        check_val("data", {16'd0, bus.deser_data_o}, {16'd0, e.data});
        if (!e.is_err)
          check_val("mod", {28'd0, bus.deser_data_mod_o}, {28'd0, e.mod});
        check_val("latency", cyc, e.cyc);
      end
    end
  end

  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      bus.ser_data_val_i = 1'b1;
      bus.ser_data_i     = bits[i];
      last_bit_cyc       = cyc;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.ser_data_val_i = 1'b0;
      bus.ser_data_i     = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic expect_word(input logic [15:0] d, input logic [3:0] m, input int lat);
    exp_t e;
    e.is_err  = 1'b0;
    e.data    = d;
    e.mod     = m;
    e.cyc     = last_bit_cyc + lat;
    sb_q.push_back(e);
    last_data = d;
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_err = 1'b1;
    e.data   = last_data;
    e.mod    = 4'd0;
    e.cyc    = last_bit_cyc + 2;
    sb_q.push_back(e);
  endtask

  initial begin
    bus.ser_data_i     = 1'b0;
    bus.ser_data_val_i = 1'b0;

    #12;
    check_val("rst_data", {16'd0, bus.deser_data_o}, 32'd0);
    check_val("rst_mod",  {28'd0, bus.deser_data_mod_o}, 32'd0);
    check_val("rst_val",  {31'd0, bus.deser_data_val_o}, 32'd0);
    check_val("rst_err",  {31'd0, bus.deser_err_o}, 32'd0);
    check_val("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    idle(2);

    // Full 16-bit frame
    busy_cnt = 0;
    send_bits(32'hA5C3, 16);
    expect_word(16'hA5C3, 4'd0, 1);
    idle(3);
    check_val("busy_cycles", busy_cnt, 32'd15);

    // Short legal frame
    send_bits(32'b10110, 5);
    expect_word(16'hB000, 4'd5, 2);
    idle(3);

    // Too-short frame, then a minimum-length frame
    send_bits(32'b10, 2);
    expect_err();
    idle(3);
    send_bits(32'b111, 3);
    expect_word(16'hE000, 4'd3, 2);
    idle(3);

    // Continuous 20-bit stream split at DATA_W
    send_bits(32'hFFFF, 16);
    expect_word(16'hFFFF, 4'd0, 1);
    send_bits(32'b1010, 4);
    expect_word(16'hA000, 4'd4, 2);
    idle(3);

    // Back-to-back frames separated by one idle cycle
    send_bits(32'h9, 4);
    expect_word(16'h9000, 4'd4, 2);
    idle(1);
    send_bits(32'h6, 4);
    expect_word(16'h6000, 4'd4, 2);
    idle(3);

    // Reset asserted mid-frame, between clock edges
    send_bits(32'b1011011, 7);
    @(posedge clk);
    #2;
    arst_n = 1'b0;
    #1;
    check_val("midrst_data", {16'd0, bus.deser_data_o}, 32'd0);
    check_val("midrst_mod",  {28'd0, bus.deser_data_mod_o}, 32'd0);
    check_val("midrst_val",  {31'd0, bus.deser_data_val_o}, 32'd0);
    check_val("midrst_err",  {31'd0, bus.deser_err_o}, 32'd0);
    check_val("midrst_busy", {31'd0, bus.busy_o}, 32'd0);
    @(negedge clk);
    bus.ser_data_val_i = 1'b0;
    arst_n             = 1'b1;
    last_data          = 16'h0000;
    idle(2);
    send_bits(32'b1100, 4);
    expect_word(16'hC000, 4'd4, 2);
    idle(3);

    for (int k = 0; k < 50 && sb_q.size() != 0; k++) @(negedge clk);
    check_val("sb_drain", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
